// File: rtl/cache_mem_arbiter.sv
// Two-requester arbiter in front of one shared block memory port (IDLE -> BUSY -> RESP).
// Optional macro CACHE_ARB_ROUND_ROBIN_EN: alternate ties; otherwise requester 0 wins ties.
// Handshake: a requester holds rX_mem_req_valid until it sees a one-cycle rX_mem_req_ready;
// memory sees mem_req_valid held with stable addr/datain/rw until mem_req_ready is sampled high.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [ADDR_W-1:0] r0_mem_req_addr,
  input  logic [DATA_W-1:0] r0_mem_req_datain,
  input  logic              r0_mem_req_rw,
  input  logic              r0_mem_req_valid,
  output logic [DATA_W-1:0] r0_mem_req_dataout,
  output logic              r0_mem_req_ready,
  input  logic [ADDR_W-1:0] r1_mem_req_addr,
  input  logic [DATA_W-1:0] r1_mem_req_datain,
  input  logic              r1_mem_req_rw,
  input  logic              r1_mem_req_valid,
  output logic [DATA_W-1:0] r1_mem_req_dataout,
  output logic              r1_mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_datain,
  output logic              mem_req_rw,
  output logic              mem_req_valid,
  input  logic [DATA_W-1:0] mem_req_dataout,
  input  logic              mem_req_ready,
  output logic              grant_id,
  output logic [1:0]        arb_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t state, state_nx;
  logic   any_valid;
  logic   win_id;
  logic   grant_now;

  assign any_valid = r0_mem_req_valid | r1_mem_req_valid;
  assign grant_now = (state == IDLE) && any_valid;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie, pick whichever requester was not granted last.
  assign win_id = r1_mem_req_valid & (~r0_mem_req_valid | ~last_grant);

  always_ff @(posedge CLK) begin
    if (RESETn) begin
      last_grant <= 1'b1;
    end else if (grant_now) begin
      last_grant <= win_id;
    end
  end
`else
  assign win_id = r1_mem_req_valid & ~r0_mem_req_valid;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_valid) state_nx = BUSY;
      BUSY:    if (mem_req_ready) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESETn) begin
      state              <= IDLE;
      grant_id           <= 1'b0;
      mem_req_addr       <= '0;
      mem_req_datain     <= '0;
      mem_req_rw         <= 1'b0;
      r0_mem_req_dataout <= '0;
      r1_mem_req_dataout <= '0;
    end else begin
      state <= state_nx;
      if (grant_now) begin
        grant_id       <= win_id;
        mem_req_addr   <= win_id ? r1_mem_req_addr   : r0_mem_req_addr;
        mem_req_datain <= win_id ? r1_mem_req_datain : r0_mem_req_datain;
        mem_req_rw     <= win_id ? r1_mem_req_rw     : r0_mem_req_rw;
      end
      // Only the winner's return register ever loads; the other holds.
      if ((state == BUSY) && mem_req_ready) begin
        if (grant_id) r1_mem_req_dataout <= mem_req_dataout;
        else          r0_mem_req_dataout <= mem_req_dataout;
      end
    end
  end

  assign mem_req_valid    = (state == BUSY);
  assign r0_mem_req_ready = (state == RESP) && !grant_id;
  assign r1_mem_req_ready = (state == RESP) &&  grant_id;
  assign arb_state        = state;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed transactions, a memory-side monitor
// and a requester-side monitor each popping their own expected queue.
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int TMO    = 200;

  logic              CLK = 1'b0;
  logic              RESETn = 1'b1;
  logic [ADDR_W-1:0] r0_addr = '0, r1_addr = '0;
  logic [DATA_W-1:0] r0_din = '0, r1_din = '0;
  logic              r0_rw = 1'b0, r1_rw = 1'b0;
  logic              r0_valid = 1'b0, r1_valid = 1'b0;
  logic [DATA_W-1:0] r0_dout, r1_dout;
  logic              r0_ready, r1_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_datain;
  logic              mem_req_rw, mem_req_valid;
  logic [DATA_W-1:0] mem_req_dataout = '0;
  logic              mem_req_ready = 1'b0;
  logic              grant_id;
  logic [1:0]        arb_state;

  int n_checks = 0;
  int n_pass   = 0;

  // {id, data} per expected ready pulse; {id, rw, addr, datain} per expected memory request
  logic [DATA_W:0]            exp_q[$];
  logic [ADDR_W+DATA_W+1:0]   exp_mem_q[$];

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .r0_mem_req_addr(r0_addr), .r0_mem_req_datain(r0_din), .r0_mem_req_rw(r0_rw),
    .r0_mem_req_valid(r0_valid), .r0_mem_req_dataout(r0_dout), .r0_mem_req_ready(r0_ready),
    .r1_mem_req_addr(r1_addr), .r1_mem_req_datain(r1_din), .r1_mem_req_rw(r1_rw),
    .r1_mem_req_valid(r1_valid), .r1_mem_req_dataout(r1_dout), .r1_mem_req_ready(r1_ready),
    .mem_req_addr(mem_req_addr), .mem_req_datain(mem_req_datain), .mem_req_rw(mem_req_rw),
    .mem_req_valid(mem_req_valid), .mem_req_dataout(mem_req_dataout),
    .mem_req_ready(mem_req_ready), .grant_id(grant_id), .arb_state(arb_state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    #1 RESETn = 1'b0;
  endtask

  task automatic set_req(input bit id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input bit rw, input bit v);
    if (id) begin r1_addr = a; r1_din = d; r1_rw = rw; r1_valid = v; end
    else    begin r0_addr = a; r0_din = d; r0_rw = rw; r0_valid = v; end
  endtask

  task automatic expect_txn(input bit id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input bit rw, input logic [DATA_W-1:0] rdata);
    exp_mem_q.push_back({id, rw, a, d});
    exp_q.push_back({id, rdata});
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO && !ok; i++) begin
      @(negedge CLK);
      if (mem_req_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL mem_req_valid_timeout: got 0 expected 1 within %0d cycles", TMO);
    end
  endtask

  // Memory answers dly negedges after mem_req_valid is seen, holding ready for hold cycles.
  task automatic mem_respond(input int dly, input logic [DATA_W-1:0] d, input int hold);
    bit ok;
    wait_valid(ok);
    if (ok) begin
      repeat (dly) @(negedge CLK);
      mem_req_dataout = d;
      mem_req_ready   = 1'b1;
      repeat (hold) @(negedge CLK);
      mem_req_ready   = 1'b0;
    end
  endtask

  // Memory-side monitor: new request must match the queue head and stay stable while valid.
  initial begin : mem_monitor
    logic [ADDR_W+DATA_W+1:0] cur;
    bit prev_valid;
    cur = '0;
    prev_valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (mem_req_valid && !RESETn) begin
        if (!prev_valid) begin
          if (exp_mem_q.size() == 0) begin
            n_checks++;
            $display("FAIL mem_req_unexpected: got addr %0h expected no request", mem_req_addr);
          end else begin
            cur = exp_mem_q.pop_front();
            check("mem_req_grant", {grant_id, mem_req_rw, mem_req_addr, mem_req_datain}, cur);
          end
        end else begin
          check("mem_req_stable", {grant_id, mem_req_rw, mem_req_addr, mem_req_datain}, cur);
        end
      end
      prev_valid = mem_req_valid;
    end
  end

  // Requester-side monitor: ready pulses pop the scoreboard; idle dataouts must hold.
  initial begin : resp_monitor
    logic [DATA_W:0]   e;
    logic [DATA_W-1:0] hold0, hold1;
    hold0 = '0;
    hold1 = '0;
    forever begin
      @(negedge CLK);
      if (RESETn) begin
        hold0 = '0;
        hold1 = '0;
      end else begin
        if (r0_ready && r1_ready) begin
          n_checks++;
          $display("FAIL ready_both: got 11 expected at most one ready");
        end else if (r0_ready || r1_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL ready_unexpected: got r0=%0b r1=%0b expected no pulse", r0_ready, r1_ready);
          end else begin
            e = exp_q.pop_front();
            check("resp_id_data", {r1_ready, r1_ready ? r1_dout : r0_dout}, e);
            if (e[DATA_W]) hold1 = e[DATA_W-1:0];
            else           hold0 = e[DATA_W-1:0];
          end
        end
        if (!r0_ready) check("r0_dout_hold", r0_dout, hold0);
        if (!r1_ready) check("r1_dout_hold", r1_dout, hold1);
      end
    end
  end

  initial begin : stimulus
    bit ok;
    repeat (2) @(negedge CLK);
    #1 RESETn = 1'b0;
    @(negedge CLK);
    check("rst_state", arb_state, 2'd0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_ready", {r0_ready, r1_ready}, 2'b00);
    check("rst_grant", grant_id, 1'b0);
    check("rst_mem_req", {mem_req_rw, mem_req_addr, mem_req_datain}, '0);
    check("rst_dout", {r0_dout, r1_dout}, '0);

    // r0 read alone, memory answers 2 cycles after valid
    expect_txn(1'b0, 32'h0000_0040, '0, 1'b0, {16{8'hA5}});
    set_req(1'b0, 32'h0000_0040, '0, 1'b0, 1'b1);
    mem_respond(2, {16{8'hA5}}, 1);
    check("r0_read_state_resp", arb_state, 2'd2);
    r0_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("r0_read_idle", arb_state, 2'd0);

    // r1 write, inputs change during BUSY
    expect_txn(1'b1, 32'h100, 128'h1234, 1'b1, 128'hBEEF);
    set_req(1'b1, 32'h100, 128'h1234, 1'b1, 1'b1);
    wait_valid(ok);
    set_req(1'b1, 32'h200, 128'h5555, 1'b0, 1'b1);
    mem_respond(3, 128'hBEEF, 1);
    r1_valid = 1'b0;
    repeat (3) @(negedge CLK);

    // simultaneous valids held over three grants
    do_reset();
    r0_addr = 32'h1000; r0_din = 128'h11; r0_rw = 1'b0;
    r1_addr = 32'h2000; r1_din = 128'h22; r1_rw = 1'b0;
    expect_txn(1'b0, 32'h1000, 128'h11, 1'b0, 128'hD1);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    expect_txn(1'b1, 32'h2000, 128'h22, 1'b0, 128'hD2);
`else
    expect_txn(1'b0, 32'h1000, 128'h11, 1'b0, 128'hD2);
`endif
    expect_txn(1'b0, 32'h1000, 128'h11, 1'b0, 128'hD3);
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    mem_respond(0, 128'hD1, 1);
    mem_respond(1, 128'hD2, 1);
    mem_respond(0, 128'hD3, 1);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("tie_idle", arb_state, 2'd0);

    // reset while BUSY with mem_req_ready on the same edge
    exp_mem_q.push_back({1'b0, 1'b0, 32'h300, 128'h0});
    set_req(1'b0, 32'h300, '0, 1'b0, 1'b1);
    wait_valid(ok);
    mem_req_dataout = 128'hDEAD;
    mem_req_ready   = 1'b1;
    RESETn          = 1'b1;
    @(negedge CLK);
    check("rstbusy_state", arb_state, 2'd0);
    check("rstbusy_outputs", {mem_req_valid, r0_ready, r1_ready, grant_id, mem_req_rw,
                              mem_req_addr}, '0);
    check("rstbusy_dout", {r0_dout, r1_dout}, '0);
    #1;
    RESETn        = 1'b0;
    mem_req_ready = 1'b0;
    r0_valid      = 1'b0;
    repeat (3) @(negedge CLK);
    check("rstbusy_after_state", arb_state, 2'd0);

    // spurious mem_req_ready in IDLE
    mem_req_dataout = 128'hBAD;
    mem_req_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("spur_idle_state", arb_state, 2'd0);
      check("spur_idle_valid", mem_req_valid, 1'b0);
    end
    mem_req_ready = 1'b0;

    // mem_req_ready left high through RESP and the following IDLE
    expect_txn(1'b1, 32'h440, 128'h77, 1'b0, 128'hCAFE);
    set_req(1'b1, 32'h440, 128'h77, 1'b0, 1'b1);
    mem_respond(0, 128'hCAFE, 1);
    r1_valid        = 1'b0;
    mem_req_ready   = 1'b1;
    mem_req_dataout = 128'hF00D;
    @(negedge CLK);
    check("spur_resp_idle", arb_state, 2'd0);
    @(negedge CLK);
    check("spur_resp_stay_idle", arb_state, 2'd0);
    mem_req_ready = 1'b0;
    repeat (3) @(negedge CLK);

    check("exp_q_empty", exp_q.size(), 0);
    check("exp_mem_q_empty", exp_mem_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
